// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, memory timeout, instret.
// Optional MULTICYCLE_CONTROL_TRAP_EN: unknown opcodes trap (o_trap) instead of retiring as NOP.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_opcode,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    input  logic             i_branch_taken,
    output logic             o_imem_ren,
    output logic             o_ir_wen,
    output logic [5:0]       o_imm_fmt,
    output logic             o_alu_imm,
    output logic             o_alu_pc,
    output logic             o_dmem_ren,
    output logic             o_dmem_wen,
    output logic             o_rd_wen,
    output logic [1:0]       o_wb_sel,
    output logic             o_pc_wen,
    output logic [1:0]       o_pc_sel,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_instret,
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    output logic             o_trap,
`endif
    output logic             o_fault
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT, S_TRAP
    } state_t;

    state_t           r_state, w_next;
    logic [6:0]       r_opc;
    logic [TW-1:0]    r_tmo;
    logic [CNT_W-1:0] r_instret;
    logic             w_tmo_hit;
    logic             w_wait;

    // one-hot {J,U,B,S,I,R}; unknown opcodes fall back to R
    function automatic logic [5:0] imm_fmt(input logic [6:0] op);
        case (op)
            OP_JAL:                     return 6'b100000;
            OP_LUI, OP_AUIPC:           return 6'b010000;
            OP_BR:                      return 6'b001000;
            OP_STORE:                   return 6'b000100;
            OP_IMM, OP_LOAD, OP_JALR:   return 6'b000010;
            default:                    return 6'b000001;
        endcase
    endfunction

    function automatic logic known(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_tmo == TMO_LAST);
    assign w_wait    = ((r_state == S_FETCH) && !i_imem_ready) ||
                       ((r_state == S_MEM)   && !i_dmem_ready);
    assign o_instret = r_instret;

    always_comb begin
        w_next     = r_state;
        o_imem_ren = 1'b0;
        o_ir_wen   = 1'b0;
        o_imm_fmt  = 6'b0;
        o_alu_imm  = 1'b0;
        o_alu_pc   = 1'b0;
        o_dmem_ren = 1'b0;
        o_dmem_wen = 1'b0;
        o_rd_wen   = 1'b0;
        o_wb_sel   = 2'b00;
        o_pc_wen   = 1'b0;
        o_pc_sel   = 2'b00;
        o_retire   = 1'b0;
        o_fault    = 1'b0;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
        o_trap     = 1'b0;
`endif
        // operand selects stay stable from EXEC through WB so the ALU result holds
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            o_imm_fmt = imm_fmt(r_opc);
            o_alu_imm = (r_opc == OP_IMM) || (r_opc == OP_LOAD) ||
                        (r_opc == OP_STORE) || (r_opc == OP_JALR);
            o_alu_pc  = (r_opc == OP_AUIPC) || (r_opc == OP_JAL);
        end
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                o_imem_ren = 1'b1;
                if (i_imem_ready) begin
                    o_ir_wen = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_tmo_hit) begin
                    w_next   = S_FAULT;
                end
            end
            S_DECODE: begin
                o_imm_fmt = imm_fmt(i_opcode);
                if (known(i_opcode)) begin
                    w_next = S_EXEC;
                end else begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                    w_next = S_TRAP;
`else
                    o_pc_wen = 1'b1;
                    o_retire = 1'b1;
                    w_next   = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (r_opc == OP_BR) begin
                    o_pc_wen = 1'b1;
                    o_pc_sel = i_branch_taken ? 2'b01 : 2'b00;
                    o_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (r_opc == OP_LOAD || r_opc == OP_STORE) begin
                    w_next   = S_MEM;
                end else begin
                    w_next   = S_WB;
                end
            end
            S_MEM: begin
                o_dmem_ren = (r_opc == OP_LOAD);
                o_dmem_wen = (r_opc == OP_STORE);
                if (i_dmem_ready) begin
                    if (r_opc == OP_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        o_pc_wen = 1'b1;
                        o_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (w_tmo_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                o_rd_wen = 1'b1;
                o_pc_wen = 1'b1;
                o_retire = 1'b1;
                w_next   = S_FETCH;
                case (r_opc)
                    OP_LOAD:          o_wb_sel = 2'b01;
                    OP_JAL, OP_JALR:  o_wb_sel = 2'b10;
                    OP_LUI:           o_wb_sel = 2'b11;
                    default:          o_wb_sel = 2'b00;
                endcase
                if (r_opc == OP_JAL)       o_pc_sel = 2'b01;
                else if (r_opc == OP_JALR) o_pc_sel = 2'b10;
            end
            S_FAULT: begin
                o_imm_fmt = 6'b0;
                o_alu_imm = 1'b0;
                o_alu_pc  = 1'b0;
                o_fault   = 1'b1;
            end
            S_TRAP: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                o_trap = 1'b1;
`endif
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_opc     <= 7'b0;
            r_tmo     <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_opc <= i_opcode;
            // counter is zero on every entry to FETCH/MEM since it clears in all other states
            if (w_wait && MEM_TIMEOUT != 0) r_tmo <= r_tmo + TW'(1);
            else                            r_tmo <= '0;
            if (o_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- FSM-based control unit for the multi-cycle RV32I core; successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath enables per state and handshakes with instruction/data memories that have variable latency.
- Adds a memory timeout fault and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for a memory ready; 0 disables the timeout.
- CNT_W, 32, width of retired-instruction counter o_instret.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_opcode  in  7  instruction[6:0] from the instruction register, valid from DECODE onward
- i_imem_ready  in  1  instruction memory read complete
- i_dmem_ready  in  1  data memory access complete
- i_branch_taken  in  1  branch comparator result, sampled in EXEC
- o_imem_ren  out  1  instruction fetch request
- o_ir_wen  out  1  load instruction register
- o_imm_fmt  out  6  one-hot {J,U,B,S,I,R}, same encoding as the single-cycle unit
- o_alu_imm  out  1  ALU operand B = immediate
- o_alu_pc  out  1  ALU operand A = PC (AUIPC, JAL target)
- o_dmem_ren  out  1  data read request
- o_dmem_wen  out  1  data write request
- o_rd_wen  out  1  register file write
- o_wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 U-immediate
- o_pc_wen  out  1  update PC
- o_pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared (JALR)
- o_retire  out  1  one-cycle pulse per completed instruction
- o_instret  out  CNT_W  retired-instruction count
- o_fault  out  1  sticky memory-timeout fault

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, all outputs 0, o_instret=0, timeout counter=0, latched opcode=0.
  - Reset asserted mid-instruction aborts immediately; no writes complete.
- States and transitions:
  - IDLE: no outputs; next cycle -> FETCH.
  - FETCH: o_imem_ren=1 held until i_imem_ready. On ready: o_ir_wen=1 that same cycle -> DECODE.
  - DECODE: latch i_opcode; drive o_imm_fmt per opcode (R for OP_REG/unknown, I for IMM/LOAD/JALR, S, B, U for LUI/AUIPC, J). Next state by opcode:
    - known opcode -> EXEC
    - unknown opcode -> see Optional Feature
  - EXEC: o_imm_fmt held from the latched opcode; o_alu_imm=1 for IMM/LOAD/STORE/JALR; o_alu_pc=1 for AUIPC/JAL.
    - BRANCH: o_pc_wen=1, o_pc_sel=01 if i_branch_taken else 00, o_retire=1 -> FETCH.
    - LOAD/STORE -> MEM.
    - All others -> WB.
  - MEM: o_dmem_ren (LOAD) or o_dmem_wen (STORE) held until i_dmem_ready.
    - LOAD on ready -> WB.
    - STORE on ready: o_pc_wen=1, o_pc_sel=00, o_retire=1 -> FETCH.
  - WB: o_rd_wen=1, o_pc_wen=1, o_retire=1 -> FETCH.
    - o_wb_sel: LOAD=01, JAL/JALR=10, LUI=11, else 00.
    - o_pc_sel: JAL=01, JALR=10, else 00.
  - FAULT: all outputs 0 except o_fault=1; remain until reset.
- Output timing:
  - Outputs are combinational from state and latched opcode (Moore), except o_ir_wen and MEM/branch completion signals, which also depend on ready or i_branch_taken.
  - No request is asserted in IDLE.
- Latency (zero-wait memory, ready high in the first request cycle):
  - ALU/LUI/JAL: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles. Store: 4 cycles. Load: 5 cycles.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle a request is pending without ready.
  - When the counter reaches MEM_TIMEOUT with ready still low -> FAULT, and the request drops.
  - Ready arriving in the same cycle the count reaches MEM_TIMEOUT counts as success.
  - MEM_TIMEOUT=0: wait indefinitely.
- Counter: o_instret increments by 1 on each o_retire and wraps modulo 2^CNT_W.
- Ready inputs are ignored outside FETCH/MEM.

Optional Feature:
- Macro MULTICYCLE_CONTROL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP state.
  - o_trap output (1 bit, added to ports) asserts and stays high, all other outputs 0, until reset.
  - o_instret does not increment.
- Undefined:
  - Unknown opcode is a NOP: DECODE asserts o_pc_wen=1, o_pc_sel=00, o_retire=1 -> FETCH.
  - No o_trap port.

Test Plan:
- Release reset, ADDI (0010011), imem ready immediately -> IDLE 1 cycle; o_ir_wen in cycle 2; o_rd_wen=1, o_wb_sel=00, o_alu_imm=1 in cycle 5; o_instret=1.
- LW (0000011), dmem ready after 3 wait cycles -> o_dmem_ren high 4 cycles; then WB with o_wb_sel=01, o_rd_wen=1; total 8 cycles.
- BEQ (1100011) with i_branch_taken=1, then again with 0 -> o_pc_sel=01 then 00 in EXEC; o_rd_wen never asserted; o_instret increments by 2.
- MEM_TIMEOUT=4, imem ready held low -> o_imem_ren for 4 cycles after IDLE, then o_fault=1 sticky; o_imem_ren=0 until reset.
- Opcode 7'b1111111 -> with macro: o_trap=1, o_instret unchanged; without macro: NOP retire in DECODE, o_instret+1, next FETCH.
- SW with i_rst_n pulled low while waiting in MEM -> o_dmem_wen drops asynchronously, o_instret=0; after release, IDLE then FETCH.
